sound_sequencer: RTL and testbench
==================================

# sound_sequencer

Event-driven melody player for the billiard game's audio path. It accepts one-cycle game events (ball hit, pocket, win), picks the highest-priority one, and steps through a short fixed melody. Notes advance on an external tick, normally the frame-start pulse. It drives `anySound` and a tone index into the tone generator. It is the producing side of the silence counter, which restarts on `anySound` and times out after sustained silence.

## Interface
Parameters:
- `NOTE_TICKS`, default 6: ticks each note is held, legal range 1..15.
- `MEL_LEN`, default 4: maximum notes per melody. The slot counter is 2 bits wide.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-cycle pulse that paces note duration.
- `hitEvent` in 1: one-cycle pulse, ball collision.
- `pocketEvent` in 1: one-cycle pulse, ball pocketed.
- `winEvent` in 1: one-cycle pulse, game won.
- `anySound` out 1: high while a note is playing.
- `toneIndex` out 4: current note, 0..11 (semitone index).
- `busy` out 1: high while a melody is active. Equals `anySound`; kept as a separate port for game-control logic.
- `soundDone` out 1: one-cycle pulse when a melody ends naturally.

## Operation
- Priority order is win (3) > pocket (2) > hit (1) > none (0). Events arriving in the same cycle resolve to the highest one.
- States:
  - IDLE: all outputs low, `toneIndex` = 0.
  - PLAY: `anySound`/`busy` = 1, `toneIndex` = ROM[melody][slot].
- IDLE -> PLAY on any event. Load that melody, set slot = 0 and `tickCnt` = 0.
- Event while in PLAY:
  - Strictly higher priority than the current melody: preempt. Reload the melody, slot = 0, `tickCnt` = 0. `soundDone` is not pulsed.
  - Equal or lower priority: ignored, no restart.
- Note advance in PLAY:
  - On `tick`, if `tickCnt` == `NOTE_TICKS`-1, clear `tickCnt` and advance the slot.
  - Otherwise, on `tick`, increment `tickCnt`.
  - Without `tick`, hold.
- End of melody, on an advance where the next slot is `MEL_LEN` or its ROM entry is END (4'hF):
  - Go to IDLE.
  - Pulse `soundDone` for one cycle.
  - `toneIndex` returns to 0.
- An event and a natural end in the same cycle: the event wins. Go to or stay in PLAY with the new melody, no `soundDone`.
- `tick` and an event in the same cycle: the event wins. The counter loads as 0 and that tick is not counted.
- Melody ROM contents (slot 0..3):
  - HIT = {7, F, F, F}
  - POCKET = {4, 7, 11, F}
  - WIN = {0, 4, 7, 11}

## Timing
- Reset values: `anySound` = 0, `busy` = 0, `toneIndex` = 0, `soundDone` = 0. State = IDLE, slot = 0, `tickCnt` = 0.
- Reset asserted mid-melody forces IDLE immediately (asynchronous). No `soundDone` pulse.
- All outputs are registered.
- Event in cycle N -> `anySound` = 1 and `toneIndex` = slot 0 in cycle N+1.
- Each note lasts exactly `NOTE_TICKS` ticks, counted from the first tick after the note starts.
- The final advancing tick in cycle M -> `anySound` = 0 and `soundDone` = 1 in cycle M+1. `soundDone` is 0 in M+2.
- `tickCnt` is 4 bits and never exceeds `NOTE_TICKS`-1, so it cannot wrap.
- The slot counter never indexes beyond `MEL_LEN`-1.

## Structure
- Package `sound_pkg`:
  - `typedef enum logic [1:0] {MEL_NONE, MEL_HIT, MEL_POCKET, MEL_WIN} melody_t`, with the encoding equal to the priority value.
  - `localparam END_NOTE = 4'hF`.
  - `typedef enum {S_IDLE, S_PLAY} seq_state_t`.
- Sub-module `sound_melody_rom`: purely combinational. Inputs melody_t and 2-bit slot; output 4-bit note.
- Top level holds the priority encoder, FSM, `tickCnt`, slot register and output registers.

## Test plan
All scenarios use `NOTE_TICKS`=3 and a tick every 4 clocks unless noted.
- Reset, then idle for 20 cycles -> all outputs stay 0, `soundDone` never pulses.
- `hitEvent` at cycle 10 -> `anySound` = 1 and `toneIndex` = 7 at cycle 11. It holds for 3 ticks, then `anySound` = 0 with a single `soundDone` pulse the cycle after the 3rd tick.
- `pocketEvent` -> `toneIndex` sequence 4, 7, 11, each held 3 ticks. Then one `soundDone`; `busy` is high throughout.
- Preemption:
  - `hitEvent` during POCKET note 2 -> ignored, sequence continues unchanged.
  - `winEvent` during POCKET note 2 -> `toneIndex` = 0 on the next cycle. WIN plays in full, with exactly one `soundDone` at the end.
- `hitEvent` and `winEvent` in the same cycle -> WIN melody (0, 4, 7, 11). `tick` in the same cycle as that event is not counted, so the first note lasts a full 3 subsequent ticks.
- Reset mid-WIN at note 3 -> outputs 0 immediately, no `soundDone`. A fresh `hitEvent` after release plays HIT normally.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and constants for the billiard game's melody sequencer.
// Melody encodings double as priority values: a larger value preempts a smaller one.
package sound_pkg;

   typedef enum logic [1:0] {
      MEL_NONE   = 2'd0,
      MEL_HIT    = 2'd1,
      MEL_POCKET = 2'd2,
      MEL_WIN    = 2'd3
   } melody_t;

   localparam logic [3:0] END_NOTE = 4'hF;

   typedef enum logic {
      S_IDLE,
      S_PLAY
   } seq_state_t;

endpackage

// File: rtl/sound_melody_rom.sv
// Fixed melody table: semitone index for each melody and slot.
// END_NOTE marks the end of a melody that is shorter than four notes.
module sound_melody_rom
   import sound_pkg::*;
(
   input  melody_t    melody,
   input  logic [1:0] slot,
   output logic [3:0] note
);

   always_comb begin
      note = END_NOTE;
      unique case (melody)
         MEL_HIT: begin
            case (slot)
               2'd0:    note = 4'd7;
               default: note = END_NOTE;
            endcase
         end
         MEL_POCKET: begin
            case (slot)
               2'd0:    note = 4'd4;
               2'd1:    note = 4'd7;
               2'd2:    note = 4'd11;
               default: note = END_NOTE;
            endcase
         end
         MEL_WIN: begin
            case (slot)
               2'd0:    note = 4'd0;
               2'd1:    note = 4'd4;
               2'd2:    note = 4'd7;
               default: note = 4'd11;
            endcase
         end
         default: note = END_NOTE;
      endcase
   end

endmodule

// File: rtl/sound_sequencer.sv
// Event-driven melody player: picks the highest-priority game event and steps
// through its melody, one note per NOTE_TICKS ticks, with registered outputs.
module sound_sequencer
   import sound_pkg::*;
#(
   parameter int NOTE_TICKS = 6,
   parameter int MEL_LEN    = 4
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       tick,
   input  logic       hitEvent,
   input  logic       pocketEvent,
   input  logic       winEvent,
   output logic       anySound,
   output logic [3:0] toneIndex,
   output logic       busy,
   output logic       soundDone
);

   seq_state_t state, nextState;
   melody_t    melody, nextMelody, eventMelody;
   logic [1:0] slot, nextSlot, slotPlusOne;
   logic [3:0] tickCnt, nextTickCnt;
   logic [3:0] nextNote, followingNote;
   logic       nextDone, lastTick, melodyEnds;

   always_comb begin
      if (winEvent)
         eventMelody = MEL_WIN;
      else if (pocketEvent)
         eventMelody = MEL_POCKET;
      else if (hitEvent)
         eventMelody = MEL_HIT;
      else
         eventMelody = MEL_NONE;
   end

   assign slotPlusOne = slot + 2'd1;

   // One ROM port looks ahead for the end marker, the other feeds the output register.
   sound_melody_rom endRom (
      .melody (melody),
      .slot   (slotPlusOne),
      .note   (followingNote)
   );

   sound_melody_rom noteRom (
      .melody (nextMelody),
      .slot   (nextSlot),
      .note   (nextNote)
   );

   assign lastTick   = tick && (tickCnt == 4'(NOTE_TICKS - 1));
   assign melodyEnds = lastTick &&
                       ((({1'b0, slot} + 3'd1) == 3'(MEL_LEN)) || (followingNote == END_NOTE));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state   <= S_IDLE;
         melody  <= MEL_NONE;
         slot    <= 2'd0;
         tickCnt <= 4'd0;
      end else begin
         state   <= nextState;
         melody  <= nextMelody;
         slot    <= nextSlot;
         tickCnt <= nextTickCnt;
      end
   end

   // An incoming event always beats a tick or a natural end in the same cycle.
   always_comb begin
      nextState   = state;
      nextMelody  = melody;
      nextSlot    = slot;
      nextTickCnt = tickCnt;
      nextDone    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (eventMelody != MEL_NONE) begin
               nextState   = S_PLAY;
               nextMelody  = eventMelody;
               nextSlot    = 2'd0;
               nextTickCnt = 4'd0;
            end
         end
         S_PLAY: begin
            if ((eventMelody > melody) || ((eventMelody != MEL_NONE) && melodyEnds)) begin
               nextMelody  = eventMelody;
               nextSlot    = 2'd0;
               nextTickCnt = 4'd0;
            end else if (melodyEnds) begin
               nextState   = S_IDLE;
               nextMelody  = MEL_NONE;
               nextSlot    = 2'd0;
               nextTickCnt = 4'd0;
               nextDone    = 1'b1;
            end else if (lastTick) begin
               nextSlot    = slotPlusOne;
               nextTickCnt = 4'd0;
            end else if (tick) begin
               nextTickCnt = tickCnt + 4'd1;
            end
         end
         default: nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         anySound  <= 1'b0;
         busy      <= 1'b0;
         toneIndex <= 4'd0;
         soundDone <= 1'b0;
      end else begin
         anySound  <= (nextState == S_PLAY);
         busy      <= (nextState == S_PLAY);
         toneIndex <= (nextState == S_PLAY) ? nextNote : 4'd0;
         soundDone <= nextDone;
      end
   end

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed scenarios plus random events and ticks,
// every cycle compared against a note/tick-count model of the melody player.
module tb_sound_sequencer;

   localparam int NT = 3;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       tick = 1'b0;
   logic       hitEvent = 1'b0;
   logic       pocketEvent = 1'b0;
   logic       winEvent = 1'b0;
   logic       anySound;
   logic [3:0] toneIndex;
   logic       busy;
   logic       soundDone;

   int compared = 0;
   int mismatched = 0;
   int cycNum = 0;

   int  melodyTable [4][4];
   bit  mActive;
   int  mMel;
   int  mSlot;
   int  mTicks;
   bit  mDone;

   sound_sequencer #(.NOTE_TICKS(NT), .MEL_LEN(4)) dut (
      .clk         (clk),
      .resetN      (resetN),
      .tick        (tick),
      .hitEvent    (hitEvent),
      .pocketEvent (pocketEvent),
      .winEvent    (winEvent),
      .anySound    (anySound),
      .toneIndex   (toneIndex),
      .busy        (busy),
      .soundDone   (soundDone)
   );

   always #5 clk = ~clk;

   function automatic void modelReset();
      mActive = 1'b0;
      mMel    = 0;
      mSlot   = 0;
      mTicks  = 0;
      mDone   = 1'b0;
   endfunction

   // One clock edge of the melody player, written as "notes held for NT ticks".
   function automatic void modelEdge(bit h, bit p, bit w, bit t);
      int  ev;
      bit  endedNow;
      ev = w ? 3 : (p ? 2 : (h ? 1 : 0));
      mDone = 1'b0;
      endedNow = 1'b0;
      if (!mActive) begin
         if (ev != 0) begin
            mActive = 1'b1; mMel = ev; mSlot = 0; mTicks = 0;
         end
         return;
      end
      if (ev > mMel) begin
         mMel = ev; mSlot = 0; mTicks = 0;
         return;
      end
      if (t) begin
         mTicks++;
         if (mTicks == NT) begin
            mTicks = 0;
            mSlot++;
            if (mSlot == 4 || melodyTable[mMel][mSlot] == 15) endedNow = 1'b1;
         end
      end
      if (endedNow) begin
         if (ev != 0) begin
            mMel = ev; mSlot = 0; mTicks = 0;
         end else begin
            mActive = 1'b0; mMel = 0; mSlot = 0; mDone = 1'b1;
         end
      end
   endfunction

   task automatic checkOutput(input string tag);
      logic [3:0] expTone;
      expTone = mActive ? 4'(melodyTable[mMel][mSlot]) : 4'd0;
      compared++;
      assert (anySound === mActive) else begin
         mismatched++;
         $error("[TB] FAIL %s.anySound cyc %0d: observed %b expected %b", tag, cycNum, anySound, mActive);
      end
      compared++;
      assert (busy === mActive) else begin
         mismatched++;
         $error("[TB] FAIL %s.busy cyc %0d: observed %b expected %b", tag, cycNum, busy, mActive);
      end
      compared++;
      assert (toneIndex === expTone) else begin
         mismatched++;
         $error("[TB] FAIL %s.toneIndex cyc %0d: observed %0d expected %0d", tag, cycNum, toneIndex, expTone);
      end
      compared++;
      assert (soundDone === mDone) else begin
         mismatched++;
         $error("[TB] FAIL %s.soundDone cyc %0d: observed %b expected %b", tag, cycNum, soundDone, mDone);
      end
   endtask

   // Ticks arrive every 4 clocks; forceTick adds one on demand.
   task automatic applyStimulus(input bit h, input bit p, input bit w, input bit forceTick, input string tag);
      bit t;
      t = forceTick || (cycNum % 4 == 0);
      hitEvent = h; pocketEvent = p; winEvent = w; tick = t;
      @(posedge clk);
      #1;
      cycNum++;
      if (!resetN) modelReset();
      else modelEdge(h, p, w, t);
      hitEvent = 1'b0; pocketEvent = 1'b0; winEvent = 1'b0; tick = 1'b0;
      checkOutput(tag);
   endtask

   task automatic runIdle(input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      melodyTable = '{'{15, 15, 15, 15}, '{7, 15, 15, 15}, '{4, 7, 11, 15}, '{0, 4, 7, 11}};
      modelReset();
      #12;
      checkOutput("reset");
      @(negedge clk);
      resetN = 1'b1;

      runIdle(20, "idle");

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "hitStart");
      runIdle(20, "hitPlay");

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "pocketStart");
      runIdle(45, "pocketPlay");

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "pocketA");
      runIdle(16, "pocketA");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "hitIgnored");
      runIdle(30, "pocketA");

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "pocketB");
      runIdle(16, "pocketB");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "winPreempt");
      runIdle(55, "winPlay");

      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, "hitWinTick");
      runIdle(55, "winTie");

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "winR");
      runIdle(27, "winR");
      @(negedge clk);
      #2;
      resetN = 1'b0;
      #1;
      modelReset();
      checkOutput("asyncReset");
      runIdle(3, "inReset");
      @(negedge clk);
      resetN = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "hitAfterReset");
      runIdle(20, "hitAfterReset");

      for (int i = 0; i < 2000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         applyStimulus(r < 4 || r == 10, (r >= 4 && r < 6) || r == 11, r == 6 || r == 11, $urandom_range(0, 3) == 0, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
